// File: rtl/core_seq_ctrl.sv
// Multi-cycle control sequencer: fetches, decodes and retires one instruction at a time,
// driving the datapath mux selects, memory handshakes and a single PC update per instruction.
module core_seq_ctrl #(
  parameter int DataSize      = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_ack,
  input  logic [DataSize-1:0] imem_rdata,
  output logic                imem_req,
  input  logic                dmem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                alu_zero,
  output logic [DataSize-1:0] instr,
  output logic [1:0]          pc_select,
  output logic [1:0]          imm_extend_select,
  output logic [2:0]          alu_src2_select,
  output logic [1:0]          write_reg_select,
  output logic [3:0]          alu_op,
  output logic                reg_write_en,
  output logic                pc_write_en,
  output logic                error
);

  localparam int              CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_COMMIT, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP
  } cls_t;

  state_t              state_q, state_nxt;
  logic [DataSize-1:0] instr_q;
  cls_t                cls_q;
  logic                bne_q;
  logic [1:0]          pc_sel_q, ext_q, wr_q;
  logic [2:0]          src2_q;
  logic [3:0]          op_q;
  logic [CntW-1:0]     cnt_q;
  logic                tmo;

  logic                dec_ok;
  cls_t                dec_cls;
  logic [1:0]          dec_pc, dec_ext, dec_wr;
  logic [2:0]          dec_src2;
  logic [3:0]          dec_op;
  logic [5:0]          opcode;

  assign opcode = instr_q[30:25];
  assign instr  = instr_q;
  assign tmo    = (cnt_q == CntLast);

  always_comb begin
    dec_ok   = 1'b1;
    dec_cls  = C_ALU;
    dec_pc   = 2'b00;
    dec_ext  = 2'b00;
    dec_src2 = 3'b000;
    dec_wr   = 2'b00;
    dec_op   = 4'd0;
    case (opcode)
      6'b100000: begin
        case (instr_q[4:0])
          5'b00000: dec_op = 4'd0;
          5'b00001: dec_op = 4'd1;
          5'b00010: dec_op = 4'd2;
          5'b00100: dec_op = 4'd3;
          5'b00011: dec_op = 4'd4;
          5'b01000: begin dec_op = 4'd5; dec_src2 = 3'b001; end
          5'b01001: begin dec_op = 4'd6; dec_src2 = 3'b001; end
          5'b01011: begin dec_op = 4'd7; dec_src2 = 3'b001; end
          default:  dec_ok = 1'b0;
        endcase
      end
      6'b101000: begin dec_src2 = 3'b001; dec_ext = 2'b01; dec_op = 4'd0; end
      6'b101100: begin dec_src2 = 3'b001; dec_ext = 2'b10; dec_op = 4'd3; end
      6'b101011: begin dec_src2 = 3'b001; dec_ext = 2'b10; dec_op = 4'd4; end
      6'b100010: begin dec_src2 = 3'b001; dec_ext = 2'b11; dec_wr = 2'b01; end
      6'b000010: begin dec_cls = C_LOAD;   dec_src2 = 3'b010; end
      6'b001010: begin dec_cls = C_STORE;  dec_src2 = 3'b010; end
      6'b100110: begin dec_cls = C_BRANCH; dec_src2 = 3'b100; dec_op = 4'd1; end
      // JAL shares the J path: no link register write is performed
      6'b100100: begin dec_cls = C_JUMP;   dec_pc = 2'b10; end
      default:   dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt         = state_q;
    imem_req          = 1'b0;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    reg_write_en      = 1'b0;
    pc_write_en       = 1'b0;
    error             = 1'b0;
    pc_select         = pc_sel_q;
    imm_extend_select = ext_q;
    alu_src2_select   = src2_q;
    write_reg_select  = wr_q;
    alu_op            = op_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)  state_nxt = S_DECODE;
        else if (tmo)  state_nxt = S_ERROR;
      end
      S_DECODE: begin
        // selects are visible while decoding, then held from the registered copy
        pc_select         = dec_pc;
        imm_extend_select = dec_ext;
        alu_src2_select   = dec_src2;
        write_reg_select  = dec_wr;
        alu_op            = dec_op;
        state_nxt         = dec_ok ? S_EXEC : S_ERROR;
      end
      S_EXEC: begin
        state_nxt = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_COMMIT;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack)  state_nxt = S_COMMIT;
        else if (tmo)  state_nxt = S_ERROR;
      end
      S_COMMIT: begin
        pc_write_en  = 1'b1;
        reg_write_en = (cls_q == C_ALU) || (cls_q == C_LOAD);
        state_nxt    = S_FETCH;
      end
      S_ERROR: error = 1'b1;
      default: state_nxt = S_ERROR;
    endcase
    // reset kills any handshake or strobe in the very cycle it is raised
    if (rst) begin
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_write_en = 1'b0;
      pc_write_en  = 1'b0;
      error        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      cls_q    <= C_ALU;
      bne_q    <= 1'b0;
      pc_sel_q <= 2'b00;
      ext_q    <= 2'b00;
      src2_q   <= 3'b000;
      wr_q     <= 2'b00;
      op_q     <= 4'd0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (imem_ack) instr_q <= imem_rdata;
        S_DECODE: if (dec_ok) begin
          cls_q    <= dec_cls;
          bne_q    <= instr_q[14];
          pc_sel_q <= dec_pc;
          ext_q    <= dec_ext;
          src2_q   <= dec_src2;
          wr_q     <= dec_wr;
          op_q     <= dec_op;
        end
        S_EXEC: if (cls_q == C_BRANCH) pc_sel_q <= (alu_zero ^ bne_q) ? 2'b01 : 2'b00;
        S_MEM:  if (dmem_ack && cls_q == C_LOAD) wr_q <= 2'b10;
        default: ;
      endcase
      // wait counter; an ack on the limit cycle wins because it is tested first
      if ((state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack))
        cnt_q <= tmo ? '0 : cnt_q + CntW'(1);
      else
        cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: linear instruction sequence with hand-computed
// select, strobe and handshake values checked by immediate assertions.
module tb_core_seq_ctrl;

  localparam logic [31:0] ADDI  = 32'h5010_0005;
  localparam logic [31:0] BEQ   = 32'h4C00_0010;
  localparam logic [31:0] BNE   = 32'h4C00_4010;
  localparam logic [31:0] LWI   = 32'h0400_0008;
  localparam logic [31:0] SWI   = 32'h1400_0008;
  localparam logic [31:0] JMP   = 32'h4800_0100;
  localparam logic [31:0] MOVI  = 32'h4400_0123;
  localparam logic [31:0] XORR  = 32'h4000_0003;
  localparam logic [31:0] BADOP = 32'h7E00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic        dmem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        alu_zero;
  logic [31:0] instr;
  logic [1:0]  pc_select;
  logic [1:0]  imm_extend_select;
  logic [2:0]  alu_src2_select;
  logic [1:0]  write_reg_select;
  logic [3:0]  alu_op;
  logic        reg_write_en;
  logic        pc_write_en;
  logic        error;

  int n_vec  = 0;
  int n_fail = 0;
  int req_cnt;
  int rwe_cnt;

  core_seq_ctrl #(.DataSize(32), .TimeoutCycles(16)) dut (
    .clk(clk), .rst(rst),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_zero(alu_zero), .instr(instr),
    .pc_select(pc_select), .imm_extend_select(imm_extend_select),
    .alu_src2_select(alu_src2_select), .write_reg_select(write_reg_select),
    .alu_op(alu_op), .reg_write_en(reg_write_en), .pc_write_en(pc_write_en),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; alu_zero = 1'b0;
    step(); step();
    chk("rst_instr", instr, 32'h0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_pc_we", {31'd0, pc_write_en}, 32'd0);
    chk("rst_sels", {20'd0, pc_select, imm_extend_select, alu_src2_select, write_reg_select, alu_op},
        32'd0);

    // ADDI with ack tied high: FETCH, DECODE, EXEC, COMMIT
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = ADDI; #1;
    chk("addi_fetch_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("addi_dec_src2", {29'd0, alu_src2_select}, 32'd1);
    chk("addi_dec_ext", {30'd0, imm_extend_select}, 32'd1);
    chk("addi_dec_op", {28'd0, alu_op}, 32'd0);
    chk("addi_dec_req_low", {31'd0, imem_req}, 32'd0);
    chk("addi_instr", instr, ADDI);
    step();
    chk("addi_exec_src2", {29'd0, alu_src2_select}, 32'd1);
    step();
    chk("addi_commit_pcwe", {31'd0, pc_write_en}, 32'd1);
    chk("addi_commit_rwe", {31'd0, reg_write_en}, 32'd1);
    chk("addi_commit_pcsel", {30'd0, pc_select}, 32'd0);

    // BEQ taken
    step(); imem_rdata = BEQ; alu_zero = 1'b1;
    step();
    chk("beq_dec_src2", {29'd0, alu_src2_select}, 32'd4);
    chk("beq_dec_op", {28'd0, alu_op}, 32'd1);
    step(); step();
    chk("beq_t_pcsel", {30'd0, pc_select}, 32'd1);
    chk("beq_t_rwe", {31'd0, reg_write_en}, 32'd0);
    chk("beq_t_pcwe", {31'd0, pc_write_en}, 32'd1);

    // BEQ not taken
    step(); alu_zero = 1'b0;
    step(); step(); step();
    chk("beq_nt_pcsel", {30'd0, pc_select}, 32'd0);

    // BNE taken on nonzero compare
    step(); imem_rdata = BNE;
    step(); step(); step();
    chk("bne_t_pcsel", {30'd0, pc_select}, 32'd1);

    // LWI with dmem_ack arriving in the fourth MEM cycle
    step(); imem_rdata = LWI; dmem_ack = 1'b0;
    step(); step();
    chk("lwi_exec_src2", {29'd0, alu_src2_select}, 32'd2);
    step();
    chk("lwi_mem_we", {31'd0, dmem_we}, 32'd0);
    req_cnt = 0;
    repeat (3) begin
      req_cnt += int'(dmem_req);
      step();
    end
    dmem_ack = 1'b1; #1;
    req_cnt += int'(dmem_req);
    step(); dmem_ack = 1'b0;
    chk("lwi_req_cycles", req_cnt, 32'd4);
    chk("lwi_commit_wsel", {30'd0, write_reg_select}, 32'd2);
    chk("lwi_commit_rwe", {31'd0, reg_write_en}, 32'd1);
    chk("lwi_commit_req_low", {31'd0, dmem_req}, 32'd0);

    // SWI with same-cycle ack
    step(); imem_rdata = SWI; dmem_ack = 1'b1;
    step(); step(); step();
    chk("swi_mem_req", {31'd0, dmem_req}, 32'd1);
    chk("swi_mem_we", {31'd0, dmem_we}, 32'd1);
    step(); dmem_ack = 1'b0;
    chk("swi_commit_rwe", {31'd0, reg_write_en}, 32'd0);
    chk("swi_commit_pcwe", {31'd0, pc_write_en}, 32'd1);

    // J: PC select held from DECODE through COMMIT, no register write
    step(); imem_rdata = JMP;
    step();
    chk("j_dec_pcsel", {30'd0, pc_select}, 32'd2);
    step(); step();
    chk("j_commit_pcsel", {30'd0, pc_select}, 32'd2);
    chk("j_commit_rwe", {31'd0, reg_write_en}, 32'd0);

    // MOVI
    step(); imem_rdata = MOVI;
    step();
    chk("movi_dec_ext", {30'd0, imm_extend_select}, 32'd3);
    chk("movi_dec_wsel", {30'd0, write_reg_select}, 32'd1);
    step(); step();
    chk("movi_commit_rwe", {31'd0, reg_write_en}, 32'd1);

    // ALU_1 xor
    step(); imem_rdata = XORR;
    step();
    chk("xor_dec_op", {28'd0, alu_op}, 32'd4);
    chk("xor_dec_src2", {29'd0, alu_src2_select}, 32'd0);
    step(); step();
    chk("xor_commit_rwe", {31'd0, reg_write_en}, 32'd1);

    // fetch timeout: 15 idle cycles still waiting, 16th traps
    step(); imem_ack = 1'b0;
    repeat (15) step();
    chk("tmo_15_error", {31'd0, error}, 32'd0);
    chk("tmo_15_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("tmo_16_error", {31'd0, error}, 32'd1);
    chk("tmo_16_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = ADDI;
    repeat (4) step();
    chk("tmo_sticky", {31'd0, error}, 32'd1);
    chk("tmo_no_pcwe", {31'd0, pc_write_en}, 32'd0);
    rst = 1'b1; step(); step();
    chk("tmo_rst_error", {31'd0, error}, 32'd0);

    // ack on the limit cycle beats the timeout
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = ADDI;
    repeat (15) step();
    imem_ack = 1'b1;
    step();
    chk("limit_ack_error", {31'd0, error}, 32'd0);
    chk("limit_ack_dec", {29'd0, alu_src2_select}, 32'd1);
    step(); step(); step();

    // illegal opcode traps after DECODE
    imem_rdata = BADOP;
    step();
    chk("bad_dec_error", {31'd0, error}, 32'd0);
    step();
    chk("bad_trap_error", {31'd0, error}, 32'd1);
    rst = 1'b1; step(); step();

    // reset during MEM of a load
    rst = 1'b0; imem_rdata = LWI; dmem_ack = 1'b0; #1;
    step(); step(); step();
    chk("rstmem_req_before", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1; #1;
    chk("rstmem_req_same", {31'd0, dmem_req}, 32'd0);
    rwe_cnt = 0;
    step();
    rwe_cnt += int'(reg_write_en);
    chk("rstmem_req_next", {31'd0, dmem_req}, 32'd0);
    chk("rstmem_instr", instr, 32'h0);
    rst = 1'b0; imem_ack = 1'b0; #1;
    chk("rstmem_fetch", {31'd0, imem_req}, 32'd1);
    repeat (4) begin
      step();
      rwe_cnt += int'(reg_write_en);
    end
    chk("rstmem_no_rwe", rwe_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle control sequencer for the core datapath: PC/immediate/ALU-operand/write-back mux network, register file, ALU, instruction and data memory ports.
- Fetches one 32-bit instruction, decodes it and drives all mux selects for the current instruction.
- Issues memory handshakes and emits exactly one PC update per retired instruction.
- Sits between the memory interfaces and the datapath; the datapath itself holds no state machine.

Parameters:
- DataSize, 32, instruction and data width.
- TimeoutCycles, 16, maximum cycles a memory request waits for its ack before the error trap.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_ack  input  1  instruction word valid on imem_rdata this cycle.
- imem_rdata  input  DataSize  fetched instruction.
- imem_req  output  1  fetch request.
- dmem_ack  input  1  data access complete.
- dmem_req  output  1  data access request.
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
- alu_zero  input  1  ALU result equals zero (branch compare).
- instr  output  DataSize  latched instruction register; feeds datapath immediate/register fields.
- pc_select  output  2  00 = +4, 01 = +imm14<<1, 10 = +imm24<<1.
- imm_extend_select  output  2  00 = imm5 ZE, 01 = imm15 SE, 10 = imm15 ZE, 11 = imm20 SE.
- alu_src2_select  output  3  000 = rb, 001 = imm, 010 = imm15<<2, 011 = rb<<sv, 100 = rt.
- write_reg_select  output  2  00 = ALU, 01 = operand mux, 10 = memory.
- alu_op  output  4  0 = add, 1 = sub, 2 = and, 3 = or, 4 = xor, 5 = sll, 6 = srl, 7 = rotr.
- reg_write_en  output  1  register file write strobe.
- pc_write_en  output  1  PC register load strobe.
- error  output  1  sticky trap flag.

Behaviour:
- Reset: state = FETCH. instr = 0. All select outputs = 0. All strobes and requests = 0. error = 0. Reset mid-handshake drops the request in the same cycle and discards any in-flight instruction.
- FETCH: imem_req = 1. When imem_ack = 1 in the same or a later cycle, latch imem_rdata into instr and go to DECODE. imem_req falls in the cycle after the ack.
- DECODE: opcode = instr[30:25]. Selects become registered and stay stable through COMMIT.
  - ALU_1 (100000): sub_op instr[4:0]: 00000 add, 00001 sub, 00010 and, 00100 or, 00011 xor with src2 = 000; 01000 slli, 01001 srli, 01011 rotri with src2 = 001, ext = 00. write = 00.
  - ADDI (101000): src2 = 001, ext = 01, add.
  - ORI (101100) / XORI (101011): src2 = 001, ext = 10.
  - MOVI (100010): src2 = 001, ext = 11, write = 01.
  - LWI (000010) / SWI (001010): src2 = 010, add.
  - BEQ/BNE (100110; instr[14] = 1 means BNE): src2 = 100, sub.
  - J/JAL (100100; instr[24] = 1 means JAL): pc_select = 10.
  - Any other opcode or sub_op: go to ERROR.
- EXEC: one cycle for the ALU result to settle. Branch decision is taken here: BEQ taken iff alu_zero = 1, BNE iff alu_zero = 0. Taken sets pc_select = 01, not taken = 00. Loads and stores go to MEM; everything else goes to COMMIT.
- MEM: dmem_req = 1, dmem_we = 1 for SWI. On dmem_ack go to COMMIT. A load sets write = 10.
- COMMIT: one cycle. pc_write_en = 1 always. reg_write_en = 1 for ALU, ADDI/ORI/XORI, MOVI and LWI; 0 for SWI, branches and J. Next state FETCH. JAL link write is not supported: JAL behaves as J.
- Latency with same-cycle acks: 4 cycles for ALU/branch/jump, 5 cycles for load/store.
- Timeout: a counter increments each cycle a request waits without ack. Reaching TimeoutCycles goes to ERROR. The counter clears on ack or on leaving the state. An ack arriving in the same cycle the counter hits its limit takes priority over the timeout.
- ERROR: all requests and strobes = 0, error = 1. Held until rst.

Test Plan:
- rst for 2 cycles, imem_ack tied high, ADDI r1,r0,5 (0x50100005) -> DECODE drives src2 = 001, ext = 01, alu_op = 0. COMMIT on cycle 4 after reset release with pc_write_en = 1, reg_write_en = 1, pc_select = 00.
- BEQ with alu_zero = 1 -> pc_select = 01 in COMMIT, reg_write_en = 0. Same instruction with alu_zero = 0 -> pc_select = 00.
- LWI with dmem_ack delayed 3 cycles -> dmem_req high for exactly 4 cycles, dmem_we = 0, write_reg_select = 10, reg_write_en = 1 in COMMIT.
- SWI -> dmem_we = 1 while dmem_req = 1, reg_write_en = 0.
- imem_ack held low for 16 cycles -> error = 1, imem_req = 0, error stays 1 until rst.
- Opcode 111111 -> ERROR after DECODE. Assert rst during MEM of a load -> next cycle dmem_req = 0, state FETCH, no reg_write_en pulse.
